// File: rtl/alu_chain_pkg.sv
// Shared types and ALU select codes for the multi-byte ALU sequencer.
package alu_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_AND = 1'b1
    } op_t;

    localparam logic [2:0] ALU_SEL_ADDC = 3'd0;
    localparam logic [2:0] ALU_SEL_AND  = 3'd7;

    function automatic logic [2:0] alu_sel(input op_t op);
        return (op == OP_AND) ? ALU_SEL_AND : ALU_SEL_ADDC;
    endfunction

endpackage

// File: rtl/alu_chain_ctrl.sv
// Drives an 8-bit ALU one byte per cycle (LSB first), chaining carry between
// bytes, and assembles a registered WIDTH-bit result with aggregate flags.
module alu_chain_ctrl
    import alu_chain_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int WIDTH = 8 * BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             res_co,
    output logic             res_ov,
    output logic             res_z,
    output logic             res_neg,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_s,
    output logic [2:0]       alu_n,
    output logic             alu_ci,
    input  logic [7:0]       alu_w,
    input  logic             alu_co,
    input  logic             alu_ov
);

    localparam int                IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);

    state_t           r_state;
    op_t              r_op;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_zacc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_co;
    logic             r_ov;
    logic             r_z;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic             w_add;
    logic             w_last;
    logic             w_wzero;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;

    assign w_run    = (r_state == RUN);
    assign w_add    = (r_op == OP_ADD);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_wzero  = (alu_w == 8'h00);
    assign w_a_byte = r_opa[{r_idx, 3'b000} +: 8];
    assign w_b_byte = r_opb[{r_idx, 3'b000} +: 8];

    // ALU drive is forced to zero outside RUN so the shared ALU sees a quiet bus.
    assign alu_a  = w_run ? w_a_byte : 8'h00;
    assign alu_b  = w_run ? w_b_byte : 8'h00;
    assign alu_s  = w_run ? alu_sel(r_op) : 3'd0;
    assign alu_n  = 3'd0;
    assign alu_ci = w_run & w_add & r_carry;

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign res_co  = r_co;
    assign res_ov  = r_ov;
    assign res_z   = r_z;
    assign res_neg = r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b1;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_ov     <= 1'b0;
            r_z      <= 1'b0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa   <= opa;
                        r_opb   <= opb;
                        r_op    <= op_t'(op);
                        r_carry <= cin & ~op;
                        r_idx   <= '0;
                        r_zacc  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[{r_idx, 3'b000} +: 8] <= alu_w;
                    r_carry <= w_add & alu_co;
                    r_zacc  <= r_zacc & w_wzero;
                    r_idx   <= r_idx + 1'b1;
                    // Top byte: the final carry is reported, never fed back to byte 0.
                    if (w_last) begin
                        r_co    <= w_add & alu_co;
                        r_ov    <= w_add & alu_ov;
                        r_z     <= r_zacc & w_wzero;
                        r_neg   <= alu_w[7];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Directed bench: alu_chain_ctrl wired to a behavioural model of the 8-bit ALU.
module tb_alu_chain_ctrl;

    localparam int BYTES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic        cin;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        res_co;
    logic        res_ov;
    logic        res_z;
    logic        res_neg;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_s;
    logic [2:0]  alu_n;
    logic        alu_ci;
    logic [7:0]  alu_w;
    logic        alu_co;
    logic        alu_ov;
    logic [8:0]  w_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_chain_ctrl #(.BYTES(BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .res_co(res_co), .res_ov(res_ov), .res_z(res_z), .res_neg(res_neg),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_n(alu_n),
        .alu_ci(alu_ci), .alu_w(alu_w), .alu_co(alu_co), .alu_ov(alu_ov)
    );

    // Reference 8-bit ALU: select 0 = add-with-carry, 7 = AND.
    always_comb begin
        w_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
        alu_w  = 8'h00;
        alu_co = 1'b0;
        alu_ov = 1'b0;
        case (alu_s)
            3'd0: begin
                alu_w  = w_sum[7:0];
                alu_co = w_sum[8];
                alu_ov = (alu_a[7] == alu_b[7]) && (w_sum[7] != alu_a[7]);
            end
            3'd7: alu_w = alu_a & alu_b;
            default: alu_w = 8'h00;
        endcase
    end

    task automatic run_cmd(input logic o, input logic c, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int bcnt, output logic [2:0] s_or,
                           output logic [2:0] s_and, output logic ci_or);
        @(negedge clk);
        op = o; cin = c; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; bcnt = 0; s_or = 3'd0; s_and = 3'b111; ci_or = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) begin
                bcnt++;
                s_or  |= alu_s;
                s_and &= alu_s;
                ci_or |= alu_ci;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; cin = 1'b0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if ({res_co, res_ov, res_z, res_neg} !== 4'b0000)
            begin bad++; $display("FAIL reset_flags: got %b want 0000", {res_co, res_ov, res_z, res_neg}); end
        total++; if ({alu_a, alu_b, alu_s, alu_n, alu_ci} !== 23'h0)
            begin bad++; $display("FAIL reset_alu_drive: got %h want 0", {alu_a, alu_b, alu_s, alu_n, alu_ci}); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_carry();
        int lat, bcnt; logic [2:0] s_or, s_and; logic ci_or;
        run_cmd(1'b0, 1'b0, 32'h000000FF, 32'h00000001, lat, bcnt, s_or, s_and, ci_or);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", lat); end
        total++; if (bcnt !== 4) begin bad++; $display("FAIL add_busy_cycles: got %0d want 4", bcnt); end
        total++; if (s_or !== 3'd0) begin bad++; $display("FAIL add_alu_sel: got %0d want 0", s_or); end
        total++; if (result !== 32'h00000100) begin bad++; $display("FAIL add_result: got %h want 00000100", result); end
        total++; if ({res_co, res_ov, res_z, res_neg} !== 4'b0000)
            begin bad++; $display("FAIL add_flags: got %b want 0000", {res_co, res_ov, res_z, res_neg}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse: got %b want 0", done); end
        total++; if (result !== 32'h00000100) begin bad++; $display("FAIL add_hold: got %h want 00000100", result); end
    endtask

    task automatic test_add_overflow();
        int lat, bcnt; logic [2:0] s_or, s_and; logic ci_or;
        run_cmd(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, lat, bcnt, s_or, s_and, ci_or);
        total++; if (result !== 32'h80000000) begin bad++; $display("FAIL ovf_result: got %h want 80000000", result); end
        total++; if ({res_co, res_ov, res_z, res_neg} !== 4'b0101)
            begin bad++; $display("FAIL ovf_flags: got %b want 0101", {res_co, res_ov, res_z, res_neg}); end
    endtask

    task automatic test_add_zero();
        int lat, bcnt; logic [2:0] s_or, s_and; logic ci_or;
        run_cmd(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, lat, bcnt, s_or, s_and, ci_or);
        total++; if (result !== 32'h00000000) begin bad++; $display("FAIL zero_result: got %h want 00000000", result); end
        total++; if ({res_co, res_ov, res_z, res_neg} !== 4'b1010)
            begin bad++; $display("FAIL zero_flags: got %b want 1010", {res_co, res_ov, res_z, res_neg}); end
    endtask

    task automatic test_and();
        int lat, bcnt; logic [2:0] s_or, s_and; logic ci_or;
        run_cmd(1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, lat, bcnt, s_or, s_and, ci_or);
        total++; if (result !== 32'h00F000F0) begin bad++; $display("FAIL and_result: got %h want 00F000F0", result); end
        total++; if ({res_co, res_ov, res_z, res_neg} !== 4'b0000)
            begin bad++; $display("FAIL and_flags: got %b want 0000", {res_co, res_ov, res_z, res_neg}); end
        total++; if ({s_or, s_and} !== 6'b111111) begin bad++; $display("FAIL and_alu_sel: got %b want 111111", {s_or, s_and}); end
        total++; if (ci_or !== 1'b0) begin bad++; $display("FAIL and_alu_ci: got %b want 0", ci_or); end
        total++; if (bcnt !== 4) begin bad++; $display("FAIL and_busy_cycles: got %0d want 4", bcnt); end
    endtask

    task automatic test_ignore_start();
        int lat, bcnt; logic [2:0] s_or, s_and; logic ci_or;
        @(negedge clk);
        op = 1'b0; cin = 1'b0; opa = 32'h11111111; opb = 32'h22222222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy_run: got %b want 1", busy); end
        repeat (2) @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", done); end
        total++; if (result !== 32'h33333333) begin bad++; $display("FAIL ign_result: got %h want 33333333", result); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ign_after_done: got %b want 00", {busy, done}); end
        total++; if (result !== 32'h33333333) begin bad++; $display("FAIL ign_hold: got %h want 33333333", result); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_not_accepted: got %b want 0", busy); end
        run_cmd(1'b0, 1'b0, 32'h00000001, 32'h00000002, lat, bcnt, s_or, s_and, ci_or);
        total++; if (result !== 32'h00000003) begin bad++; $display("FAIL ign_next_cmd: got %h want 00000003", result); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, seen; logic [2:0] s_or, s_and; logic ci_or;
        @(negedge clk);
        op = 1'b0; cin = 1'b0; opa = 32'h01010101; opb = 32'h01010101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_run_ctrl: got %b want 00", {busy, done}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_run_result: got %h want 00000000", result); end
        total++; if ({res_co, res_ov, res_z, res_neg, alu_a} !== 12'h0)
            begin bad++; $display("FAIL rst_run_flags: got %h want 000", {res_co, res_ov, res_z, res_neg, alu_a}); end
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_run_no_done: got %0d want 0", seen); end
        run_cmd(1'b0, 1'b0, 32'h01010101, 32'h01010101, lat, bcnt, s_or, s_and, ci_or);
        total++; if (result !== 32'h02020202) begin bad++; $display("FAIL rst_run_next: got %h want 02020202", result); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, ndone;
        c1 = -1; c2 = -1; ndone = 0;
        @(negedge clk);
        op = 1'b0; cin = 1'b0; opa = 32'h000000FF; opb = 32'h00000001; start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    c1 = cyc;
                    total++; if (result !== 32'h00000100) begin bad++; $display("FAIL b2b_first: got %h want 00000100", result); end
                    opa = 32'h12345678; opb = 32'h11111111;
                end else begin
                    c2 = cyc;
                    total++; if (result !== 32'h23456789) begin bad++; $display("FAIL b2b_second: got %h want 23456789", result); end
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        total++; if (c2 - c1 !== 6 || c1 < 0 || c2 < 0)
            begin bad++; $display("FAIL b2b_spacing: got %0d (c1=%0d c2=%0d) want 6", c2 - c1, c1, c2); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_add_overflow();
        test_add_zero();
        test_and();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
